// File: rtl/seg_scan_decoder_if.sv
// Segment/anode tap and recovered-digit outputs of the scan decoder.
// The master drives the display lines; the slave is the decoder.
interface seg_scan_decoder_if;
  logic [6:0]  nSEG;
  logic [3:0]  nAN;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        err;
  logic        err_sticky;

  modport master (
    output nSEG, nAN,
    input  digits, blank, frame_valid, err, err_sticky
  );

  modport slave (
    input  nSEG, nAN,
    output digits, blank, frame_valid, err, err_sticky
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from multiplexed active-low 7-segment scan lines.
// A digit commits after STABLE_CYCLES identical single-anode samples.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  seg_scan_decoder_if.slave bus
);
  localparam logic [7:0] ST    = 8'(STABLE_CYCLES);
  localparam logic [7:0] ST_M1 = 8'(STABLE_CYCLES - 1);

  logic [6:0]  nseg_s1_q, nseg_s2_q;
  logic [3:0]  nan_s1_q, nan_s2_q;
  logic [10:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  sblank_q, sblank_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  blank_q, blank_d;
  logic        fv_q, fv_d;
  logic        err_q, err_d;
  logic        sticky_q, sticky_d;

  logic [6:0]  seg;
  logic [3:0]  an;
  logic [10:0] samp;
  logic        valid;
  logic [1:0]  idx;
  logic [3:0]  onehot;
  logic        legal;
  logic        is_blank;
  logic [3:0]  code;
  logic        same;
  logic        commit;
  logic        full;

  assign seg  = ~nseg_s2_q;
  assign an   = ~nan_s2_q;
  assign samp = {an, seg};
  assign same = (samp == prev_q);

  always_comb begin
    valid = 1'b1;
    idx   = 2'd0;
    case (an)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: valid = 1'b0;
    endcase
  end

  assign onehot = 4'b0001 << idx;

  // Lamp test (all segments) falls out as 8.
  always_comb begin
    legal    = 1'b1;
    is_blank = 1'b0;
    code     = 4'd0;
    case (seg)
      7'b1111110: code = 4'd0;
      7'b0110000: code = 4'd1;
      7'b1101101: code = 4'd2;
      7'b1111001: code = 4'd3;
      7'b0110011: code = 4'd4;
      7'b1011011: code = 4'd5;
      7'b1011111: code = 4'd6;
      7'b1110000: code = 4'd7;
      7'b1111111: code = 4'd8;
      7'b1111011: code = 4'd9;
      7'b0000000: is_blank = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = 8'd0;
    if (valid) begin
      if (!same)
        cnt_d = 8'd1;
      else if (cnt_q == ST)
        cnt_d = cnt_q;
      else
        cnt_d = cnt_q + 8'd1;
    end
  end

  assign commit = valid && same && (cnt_q == ST_M1);
  assign full   = ((seen_q | onehot) == 4'hF);

  always_comb begin
    shadow_d = shadow_q;
    sblank_d = sblank_q;
    seen_d   = seen_q;
    digits_d = digits_q;
    blank_d  = blank_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    if (commit && legal) begin
      shadow_d[{idx, 2'b00} +: 4] = code;
      sblank_d[idx]               = is_blank;
      if (full) begin
        digits_d = shadow_d;
        blank_d  = sblank_d;
        fv_d     = 1'b1;
        seen_d   = 4'h0;
      end else begin
        seen_d = seen_q | onehot;
      end
    end else if (commit) begin
      err_d    = 1'b1;
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nseg_s1_q <= '1;
      nseg_s2_q <= '1;
      nan_s1_q  <= '1;
      nan_s2_q  <= '1;
      prev_q    <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      sblank_q  <= 4'hF;
      seen_q    <= '0;
      digits_q  <= '0;
      blank_q   <= 4'hF;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      nseg_s1_q <= bus.nSEG;
      nseg_s2_q <= nseg_s1_q;
      nan_s1_q  <= bus.nAN;
      nan_s2_q  <= nan_s1_q;
      prev_q    <= samp;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      sblank_q  <= sblank_d;
      seen_q    <= seen_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.blank       = blank_q;
  assign bus.frame_valid = fv_q;
  assign bus.err         = err_q;
  assign bus.err_sticky  = sticky_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: run-length reference model plus
// directed scans and randomized scan traffic.
module tb_seg_scan_decoder;
  localparam int ST = 4;
  localparam logic [6:0] SEGTAB [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(.STABLE_CYCLES(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  // reference model state
  logic [10:0] cap0 = '1, cap1 = '1;
  logic [10:0] last = '0;
  int          run  = 0;
  logic [3:0]  msh [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0]  mbsh  = 4'hF;
  logic [3:0]  mseen = 4'h0;
  logic [15:0] mdig  = 16'h0;
  logic [3:0]  mblk  = 4'hF;
  bit          mfv = 0, merr = 0, mst = 0;

  function automatic void mdecode(input logic [6:0] s, output bit ok,
                                  output bit bl, output int code);
    ok = 0; bl = 0; code = 0;
    if (s == 7'd0) begin ok = 1; bl = 1; end
    for (int v = 0; v < 10; v++)
      if (SEGTAB[v] == s) begin ok = 1; code = v; end
  endfunction

  task automatic model_reset();
    cap0 = '1; cap1 = '1; last = '0; run = 0;
    for (int i = 0; i < 4; i++) msh[i] = 4'h0;
    mbsh = 4'hF; mseen = 4'h0; mdig = 16'h0; mblk = 4'hF;
    mfv = 0; merr = 0; mst = 0;
  endtask

  task automatic model_step();
    logic [10:0] samp;
    logic [3:0]  an;
    bit ok, bl, valid;
    int code, di;
    samp = ~cap1;
    cap1 = cap0;
    cap0 = {bus.nAN, bus.nSEG};
    an = samp[10:7];
    valid = ($countones(an) == 1);
    if (valid && samp == last) run++;
    else run = valid ? 1 : 0;
    last = samp;
    mfv = 0; merr = 0;
    if (run == ST) begin
      di = 0;
      for (int i = 0; i < 4; i++) if (an[i]) di = i;
      mdecode(samp[6:0], ok, bl, code);
      if (ok) begin
        msh[di] = 4'(code);
        mbsh[di] = bl;
        mseen[di] = 1'b1;
        if (mseen == 4'hF) begin
          for (int i = 0; i < 4; i++) mdig[4*i +: 4] = msh[i];
          mblk = mbsh; mfv = 1; mseen = 4'h0;
        end
      end else begin
        merr = 1; mst = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    total++;
    if (bus.digits !== mdig || bus.blank !== mblk ||
        bus.frame_valid !== mfv || bus.err !== merr ||
        bus.err_sticky !== mst) begin
      bad++;
      $display("FAIL model cyc=%0d got dig=%h blk=%h fv=%b err=%b st=%b want dig=%h blk=%h fv=%b err=%b st=%b",
        cyc, bus.digits, bus.blank, bus.frame_valid, bus.err,
        bus.err_sticky, mdig, mblk, mfv, merr, mst);
    end
    if (bus.frame_valid === 1'b1) fv_cnt++;
    if (bus.err === 1'b1) err_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic hold(input int d, input logic [6:0] s, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    bus.nAN  = ~oh;
    bus.nSEG = ~s;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.nAN  = 4'hF;
    bus.nSEG = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int v3, input int v2, input int v1, input int v0);
    hold(3, SEGTAB[v3], 10);
    hold(2, SEGTAB[v2], 10);
    hold(1, SEGTAB[v1], 10);
    hold(0, SEGTAB[v0], 10);
    idle(6);
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int f0, e0, lat;
    bus.nAN  = 4'hF;
    bus.nSEG = 7'h7F;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_digits", 32'(bus.digits), 32'h0);
    check("reset_blank", 32'(bus.blank), 32'hF);
    check("reset_sticky", 32'(bus.err_sticky), 32'h0);

    f0 = fv_cnt;
    scan(1, 2, 3, 4);
    check("scan1234_fv", 32'(fv_cnt - f0), 32'd1);
    check("scan1234_digits", 32'(bus.digits), 32'h1234);
    check("scan1234_blank", 32'(bus.blank), 32'h0);
    check("scan1234_sticky", 32'(bus.err_sticky), 32'h0);

    f0 = fv_cnt;
    hold(3, SEGTAB[9], 10);
    hold(2, SEGTAB[8], 10);
    hold(1, SEGTAB[7], 10);
    idle(3);
    hold(0, SEGTAB[5], 3);
    idle(10);
    check("hold3_no_fv", 32'(fv_cnt - f0), 32'd0);
    check("hold3_digits", 32'(bus.digits), 32'h1234);
    bus.nAN = 4'b1110;
    bus.nSEG = ~SEGTAB[5];
    lat = -1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 3) begin bus.nAN = 4'hF; bus.nSEG = 7'h7F; end
      if (bus.frame_valid === 1'b1 && lat < 0) lat = j;
    end
    check("hold4_latency", 32'(lat), 32'd5);
    check("hold4_digits", 32'(bus.digits), 32'h9875);

    hold(3, SEGTAB[7], 10);
    hold(2, 7'b0000000, 10);
    hold(1, SEGTAB[0], 10);
    hold(0, SEGTAB[9], 10);
    idle(6);
    check("blank_mask", 32'(bus.blank), 32'h4);
    check("blank_digits", 32'(bus.digits), 32'h7009);

    f0 = fv_cnt; e0 = err_cnt;
    hold(3, SEGTAB[1], 10);
    hold(2, SEGTAB[2], 10);
    hold(1, 7'b1000001, 10);
    hold(0, SEGTAB[3], 10);
    idle(6);
    check("illegal_err", 32'(err_cnt - e0), 32'd1);
    check("illegal_sticky", 32'(bus.err_sticky), 32'h1);
    check("illegal_no_fv", 32'(fv_cnt - f0), 32'd0);
    hold(1, SEGTAB[4], 10);
    idle(6);
    check("fix_fv", 32'(fv_cnt - f0), 32'd1);
    check("fix_digits", 32'(bus.digits), 32'h1243);

    f0 = fv_cnt; e0 = err_cnt;
    bus.nAN = 4'b1001;
    bus.nSEG = ~SEGTAB[6];
    repeat (20) @(negedge clk);
    hold(3, SEGTAB[5], 10);
    hold(0, SEGTAB[6], 2);
    hold(2, SEGTAB[7], 10);
    idle(6);
    check("multi_glitch_fv", 32'(fv_cnt - f0), 32'd0);
    check("multi_glitch_err", 32'(err_cnt - e0), 32'd0);

    hold(1, SEGTAB[2], 10);
    pulse_rst();
    check("midrst_digits", 32'(bus.digits), 32'h0);
    check("midrst_blank", 32'(bus.blank), 32'hF);
    check("midrst_sticky", 32'(bus.err_sticky), 32'h0);
    f0 = fv_cnt;
    hold(0, SEGTAB[8], 10);
    idle(6);
    check("partial_no_fv", 32'(fv_cnt - f0), 32'd0);
    check("partial_digits", 32'(bus.digits), 32'h0);
    scan(5, 6, 7, 8);
    check("postrst_fv", 32'(fv_cnt - f0), 32'd1);
    check("postrst_digits", 32'(bus.digits), 32'h5678);

    for (int n = 0; n < 400; n++) begin
      int k, d, len;
      logic [3:0] an;
      d = $urandom_range(0, 3);
      len = $urandom_range(1, 8);
      k = $urandom_range(0, 11);
      if (k < 6)
        hold(d, SEGTAB[$urandom_range(0, 9)], len);
      else if (k == 6)
        hold(d, 7'b0000000, len);
      else if (k == 7)
        hold(d, 7'($urandom), len);
      else if (k == 8) begin
        an = 4'($urandom);
        bus.nAN = ~an;
        bus.nSEG = ~SEGTAB[$urandom_range(0, 9)];
        repeat (len) @(negedge clk);
      end else if (k == 9 && $urandom_range(0, 15) == 0)
        pulse_rst();
      else
        hold(d, SEGTAB[$urandom_range(0, 9)], len + 4);
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the BCD-to-7-segment path. It samples the multiplexed, active-low segment and anode lines driving a 4-digit Nexys display and recovers each digit's BCD value. It presents the recovered 4-digit value once all four digits have been seen stably. It sits on the board-test/self-check path, tapping the same lines the display scanner drives.

## Interface
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is committed (legal range 2–255).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- nSEG  in  7  active-low segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- nAN  in  4  active-low digit enables; bit i selects digit i (digit 0 = rightmost).
- digits  out  16  committed BCD value; digit i is in [4i+3:4i].
- blank  out  4  bit i set when digit i was committed as blank.
- frame_valid  out  1  one-cycle pulse when digits/blank update.
- err  out  1  one-cycle pulse on commit of an undecodable pattern.
- err_sticky  out  1  set with err; cleared only by rst.

## Operation
- Input capture: nSEG and nAN each pass a 2-flop synchronizer. Define SEG = ~synced nSEG and AN = ~synced nAN.
- Sample is *valid* when AN has exactly one bit set; index = that bit position.
- Decode table (SEG abcdefg -> code):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - 0000000->blank
  - Any other pattern is illegal. An all-segments lamp test decodes as 8.
- Stability counter cnt (8 bits) and previous-sample register {prev_an, prev_seg}:
  - Sample invalid -> cnt=0.
  - Sample valid and equal to previous -> cnt increments, saturating at STABLE_CYCLES.
  - Sample valid but differs -> cnt=1.
  - Previous register loads every cycle.
- Commit fires on the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES. This is exactly once per held pattern; a held pattern never recommits.
- Commit of a legal pattern:
  - shadow[index] <= code; shadow_blank[index] <= (pattern==blank; code 0).
  - seen[index] <= 1.
  - Recommitting an already-seen digit overwrites its shadow value.
- Commit of an illegal pattern: err=1 for one cycle, err_sticky=1. Shadow and seen are unchanged.
- Frame completion: if (seen | onehot(index)) == 4'hF on a legal commit, then on the same edge:
  - digits/blank load from shadow, including the new digit;
  - frame_valid=1 for that cycle;
  - seen <= 0.
- Invalid samples (no anode, or multiple anodes) are ignored apart from resetting cnt. They are not errors.

## Timing
- Reset values: digits=16'h0000, blank=4'hF, frame_valid=0, err=0, err_sticky=0. Internally: seen=0, cnt=0, shadow=0, shadow_blank=4'hF, synchronizers=1 (inactive).
- rst asserted mid-operation clears everything immediately. A partially collected frame is discarded, and the first frame after release needs all four digits again.
- Latency: a pattern first present at the input before edge k produces its commit at edge k+1+STABLE_CYCLES. That is 2 synchronizer stages, plus STABLE_CYCLES samples, minus 1 for the overlapping first sample.
- frame_valid and err are registered single-cycle pulses. They can never both be high in the same cycle.
- With STABLE_CYCLES=4, a 1 kHz/100 MHz scan gives ~100k cycles per digit, so each digit commits once per visit.

## Test plan
- Reset, then scan digits 3..0 showing 1,2,3,4, each held 10 cycles (STABLE_CYCLES=4):
  - frame_valid pulses once;
  - digits=16'h1234, blank=4'h0, err_sticky=0.
- Single digit held exactly 3 cycles, then anodes all high: no commit; seen and outputs unchanged. Repeat with 4 cycles: commit occurs on the cycle predicted by the latency rule.
- Digit 2 blank (all nSEG high), others 7,0,9:
  - blank=4'b0100;
  - digits[11:8]=0, digits[15:12]=7, digits[7:4]=0, digits[3:0]=9.
- Digit 1 shows illegal pattern 1000001 for 10 cycles:
  - err pulses once, err_sticky=1;
  - no frame_valid until a legal value is committed on digit 1.
- Two anodes low for 20 cycles: no commit and no err. Single-anode glitch of 2 cycles between digits is also ignored.
- Three digits committed, then rst pulsed mid-scan, then full scan of 5,6,7,8:
  - outputs are at reset values during the partial frame;
  - exactly one frame_valid with digits=16'h5678.
